// File: rtl/gpr_dump_engine_if.sv
// Register-file read port plus byte-stream output of the GPR dump engine.
// Latency: none (wires only).
// Backpressure: out_ready from the sink stalls the stream; rd_data has no flow control.
interface gpr_dump_engine_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
);
    // register-file read port (combinational read)
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;

    // dump stream
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] out_addr;
    logic              out_last;

    // engine side
    modport master (
        output rd_addr,
        input  rd_data,
        output out_valid,
        input  out_ready,
        output out_data,
        output out_addr,
        output out_last
    );

    // register file + sink side
    modport slave (
        input  rd_addr,
        output rd_data,
        input  out_valid,
        output out_ready,
        input  out_data,
        input  out_addr,
        input  out_last
    );
endinterface

// File: rtl/gpr_dump_engine.sv
// Walks the register-file read port over 0..NUM_REGS-1 and streams each value tagged with its address.
// Latency: 2 cycles per register (FETCH + SEND) with out_ready high; done in the cycle after the last handshake.
// Backpressure: a presented beat is held stable in SEND until out_valid && out_ready; no beat dropped or repeated.
// Optional: define GPR_DUMP_CHECKSUM_EN to append an XOR checksum beat (addr 0, out_last=1) after the registers.
module gpr_dump_engine #(
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    gpr_dump_engine_if.master bus
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_SEND  = 3'd2,
`ifdef GPR_DUMP_CHECKSUM_EN
        ST_CSUM  = 3'd4,
`endif
        ST_DONE  = 3'd3
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_index;
    logic              r_busy;
    logic              r_done;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic [ADDR_W-1:0] r_out_addr;
    logic              r_out_last;
`ifdef GPR_DUMP_CHECKSUM_EN
    logic [DATA_W-1:0] r_acc;
`endif

    logic              w_at_last;
    logic              w_hs;

    assign w_at_last = (r_index == LAST_IDX);
    assign w_hs      = r_out_valid && bus.out_ready;

    // The read address is the index counter itself; the top level muxes it in while busy.
    assign bus.rd_addr   = r_index;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_addr  = r_out_addr;
    assign bus.out_last  = r_out_last;
    assign busy          = r_busy;
    assign done          = r_done;

    // Dump sequencer: all outputs are registered; index only advances after a handshake and stops at LAST_IDX.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_index     <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_addr  <= '0;
            r_out_last  <= 1'b0;
`ifdef GPR_DUMP_CHECKSUM_EN
            r_acc       <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_index <= '0;
                        r_busy  <= 1'b1;
`ifdef GPR_DUMP_CHECKSUM_EN
                        r_acc   <= '0;
`endif
                        r_state <= ST_FETCH;
                    end
                end

                // Sample the register in its own cycle; a write landing on this edge is not seen.
                ST_FETCH: begin
                    r_out_data  <= bus.rd_data;
                    r_out_addr  <= r_index;
                    r_out_valid <= 1'b1;
`ifdef GPR_DUMP_CHECKSUM_EN
                    r_out_last  <= 1'b0;
`else
                    r_out_last  <= w_at_last;
`endif
                    r_state     <= ST_SEND;
                end

                ST_SEND: begin
                    if (w_hs) begin
                        r_out_valid <= 1'b0;
`ifdef GPR_DUMP_CHECKSUM_EN
                        r_acc       <= r_acc ^ r_out_data;
`endif
                        if (w_at_last) begin
`ifdef GPR_DUMP_CHECKSUM_EN
                            // Checksum beat follows immediately and folds in the final register.
                            r_out_data  <= r_acc ^ r_out_data;
                            r_out_addr  <= '0;
                            r_out_last  <= 1'b1;
                            r_out_valid <= 1'b1;
                            r_state     <= ST_CSUM;
`else
                            r_out_last  <= 1'b0;
                            r_done      <= 1'b1;
                            r_state     <= ST_DONE;
`endif
                        end else begin
                            r_index <= r_index + ADDR_W'(1);
                            r_state <= ST_FETCH;
                        end
                    end
                end

`ifdef GPR_DUMP_CHECKSUM_EN
                ST_CSUM: begin
                    if (w_hs) begin
                        r_out_valid <= 1'b0;
                        r_out_last  <= 1'b0;
                        r_done      <= 1'b1;
                        r_state     <= ST_DONE;
                    end
                end
`endif

                // One-cycle done pulse; start is ignored here and busy drops on the way out.
                ST_DONE: begin
                    r_out_last <= 1'b0;
                    r_busy     <= 1'b0;
                    r_state    <= ST_IDLE;
                end

                default: begin
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gpr_dump_engine.sv
// Randomized scoreboard bench for gpr_dump_engine with a behavioural register-file model.
module tb_gpr_dump_engine;
    localparam int DW = 8;
    localparam int AW = 3;
    localparam int NR = 8;

    logic clk = 1'b0;
    logic rst_n;
    logic start;
    logic busy;
    logic done;

    gpr_dump_engine_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    gpr_dump_engine #(.DATA_W(DW), .NUM_REGS(NR), .ADDR_W(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .busy  (busy),
        .done  (done),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // register file: clocked write, combinational read
    logic [DW-1:0] rf [NR];
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    always @(posedge clk) if (we) rf[wa] <= wd;
    assign bus.rd_data = rf[bus.rd_addr];

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    beat_t exp_q[$];
    int    checks = 0;
    int    passes = 0;
    int    done_cnt = 0;

    // planned register writes during a dump: issued while beat wr_b is presented
    int            wr_b [2];
    int            wr_r [2];
    logic [DW-1:0] wr_v [2];

    task automatic chk(input bit ok, input string name, input string det);
        checks++;
        if (ok) passes++;
        else $display("FAIL %s: %s", name, det);
    endtask

    // monitor: pop and compare every accepted beat, check hold during stalls, count done pulses
    initial begin
        beat_t cur;
        beat_t e;
        beat_t held;
        bit    stall;
        stall = 1'b0;
        held  = '0;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n !== 1'b1) begin
                stall = 1'b0;
                continue;
            end
            if (done) done_cnt++;
            cur = '{addr: bus.out_addr, data: bus.out_data, last: bus.out_last};
            if (stall)
                chk(bus.out_valid && cur == held, "hold",
                    $sformatf("got v=%0b a=%0d d=%h l=%0b need v=1 a=%0d d=%h l=%0b",
                              bus.out_valid, cur.addr, cur.data, cur.last, held.addr, held.data, held.last));
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    chk(1'b0, "extra_beat", $sformatf("got a=%0d d=%h need no beat", cur.addr, cur.data));
                end else begin
                    e = exp_q.pop_front();
                    chk(cur == e, "beat",
                        $sformatf("got a=%0d d=%h l=%0b need a=%0d d=%h l=%0b",
                                  cur.addr, cur.data, cur.last, e.addr, e.data, e.last));
                end
                stall = 1'b0;
            end else if (bus.out_valid) begin
                stall = 1'b1;
                held  = cur;
            end else begin
                stall = 1'b0;
            end
        end
    end

    task automatic chk_reset(input string tag);
        chk(busy == 1'b0,          {tag, "_busy"},  $sformatf("got %0b need 0", busy));
        chk(done == 1'b0,          {tag, "_done"},  $sformatf("got %0b need 0", done));
        chk(bus.out_valid == 1'b0, {tag, "_valid"}, $sformatf("got %0b need 0", bus.out_valid));
        chk(bus.out_data == '0,    {tag, "_data"},  $sformatf("got %h need 00", bus.out_data));
        chk(bus.out_addr == '0,    {tag, "_addr"},  $sformatf("got %0d need 0", bus.out_addr));
        chk(bus.out_last == 1'b0,  {tag, "_last"},  $sformatf("got %0b need 0", bus.out_last));
        chk(bus.rd_addr == '0,     {tag, "_rdaddr"}, $sformatf("got %0d need 0", bus.rd_addr));
    endtask

    task automatic load_rf(input int pat);
        for (int i = 0; i < NR; i++) begin
            @(negedge clk);
            we = 1'b1;
            wa = AW'(i);
            case (pat)
                0:       wd = DW'(((i + 1) << 4) | i);
                1:       wd = DW'(1 << i);
                default: wd = DW'($urandom_range(0, 255));
            endcase
        end
        @(negedge clk);
        we = 1'b0;
    endtask

    function automatic logic rdy(input int mode, input int p);
        case (mode)
            0:       return 1'b1;
            2:       return (p % 4 == 0) || (p % 4 == 3);
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    // mode: 0 ready high, 1 random ready, 2 ready 1-0-0-1 pattern
    task automatic run_dump(input int mode, input int nw, input bit mid_start,
                            input bit done_start, input int rst_beat);
        logic [DW-1:0] img [NR];
        logic [DW-1:0] x;
        beat_t         b;
        bit            fired [2];
        bit            mid_done;
        bit            got_done;
        int            d0;
        int            lat;
        int            p;

        // expected stream: register image at start, plus writes to registers not yet fetched
        x = '0;
        for (int i = 0; i < NR; i++) img[i] = rf[i];
        for (int w = 0; w < nw; w++) if (wr_r[w] > wr_b[w]) img[wr_r[w]] = wr_v[w];
        for (int k = 0; k < NR; k++) begin
            b.addr = AW'(k);
            b.data = img[k];
`ifdef GPR_DUMP_CHECKSUM_EN
            b.last = 1'b0;
`else
            b.last = (k == NR - 1);
`endif
            exp_q.push_back(b);
            x = x ^ img[k];
        end
`ifdef GPR_DUMP_CHECKSUM_EN
        exp_q.push_back('{addr: '0, data: x, last: 1'b1});
        lat = 2 * NR + 2;
`else
        lat = 2 * NR + 1;
`endif
        fired[0] = 1'b0;
        fired[1] = 1'b0;
        mid_done = 1'b0;
        got_done = 1'b0;
        d0 = done_cnt;
        p  = 0;

        @(negedge clk);
        chk(!busy, "idle_before_start", $sformatf("got busy=%0b need 0", busy));
        start = 1'b1;
        bus.out_ready = rdy(mode, p);
        p++;
        for (int n = 1; n <= 400; n++) begin
            @(negedge clk);
            if (n == 1) chk(busy, "busy_after_start", $sformatf("got %0b need 1", busy));
            start = 1'b0;
            we    = 1'b0;
            if (mid_start && !mid_done && bus.out_valid && bus.out_addr == AW'(3)) begin
                start    = 1'b1;
                mid_done = 1'b1;
            end
            for (int w = 0; w < nw; w++) begin
                if (!fired[w] && !we && bus.out_valid && bus.out_addr == AW'(wr_b[w])) begin
                    we = 1'b1;
                    wa = AW'(wr_r[w]);
                    wd = wr_v[w];
                    fired[w] = 1'b1;
                end
            end
            bus.out_ready = rdy(mode, p);
            p++;
            if (rst_beat >= 0 && bus.out_valid && bus.out_addr == AW'(rst_beat)) begin
                rst_n = 1'b0;
                we    = 1'b0;
                start = 1'b0;
                #1;
                chk_reset("midrst");
                @(negedge clk);
                rst_n = 1'b1;
                exp_q.delete();
                chk(done_cnt == d0, "no_done_on_reset", $sformatf("got %0d pulses need 0", done_cnt - d0));
                return;
            end
            if (done) begin
                got_done = 1'b1;
                we = 1'b0;
                if (mode == 0) chk(n == lat, "done_latency", $sformatf("got cycle %0d need %0d", n, lat));
                chk(exp_q.size() == 0, "beats_complete", $sformatf("got %0d left need 0", exp_q.size()));
                start = done_start;
                @(negedge clk);
                start = 1'b0;
                chk(!busy, "busy_clear", $sformatf("got %0b need 0", busy));
                repeat (3) @(negedge clk);
                chk(!busy && !bus.out_valid && done_cnt == d0 + 1, "single_dump",
                    $sformatf("got busy=%0b valid=%0b pulses=%0d need 0 0 1", busy, bus.out_valid, done_cnt - d0));
                break;
            end
        end
        if (!got_done) begin
            chk(1'b0, "timeout", "got no done pulse within 400 cycles need one");
            exp_q.delete();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached need summary first");
        $fatal(1);
    end

    initial begin
        we = 1'b0;
        wa = '0;
        wd = '0;
        start = 1'b0;
        bus.out_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_reset("por");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk_reset("idle");

        // directed: ready high, ready 1-0-0-1, random ready
        load_rf(0);
        run_dump(0, 0, 1'b0, 1'b0, -1);
        run_dump(2, 0, 1'b0, 1'b0, -1);
        run_dump(1, 0, 1'b0, 1'b0, -1);

        // start re-pulsed mid-dump and in the DONE cycle
        run_dump(0, 0, 1'b1, 1'b1, -1);

        // write reg5 during beat 2 (visible), reg1 during beat 3 (not visible)
        wr_b[0] = 2; wr_r[0] = 5; wr_v[0] = 8'hAA;
        wr_b[1] = 3; wr_r[1] = 1; wr_v[1] = 8'h55;
        run_dump(0, 2, 1'b0, 1'b0, -1);

        // reset during beat 4, then a full dump from addr 0
        load_rf(0);
        run_dump(1, 0, 1'b0, 1'b0, 4);
        run_dump(0, 0, 1'b0, 1'b0, -1);

        // randomized register contents, writes and backpressure
        for (int r = 0; r < 6; r++) begin
            load_rf(2);
            wr_b[0] = $urandom_range(0, 2);
            wr_b[1] = $urandom_range(3, 6);
            wr_r[0] = $urandom_range(0, NR - 1);
            wr_r[1] = $urandom_range(0, NR - 1);
            wr_v[0] = DW'($urandom_range(0, 255));
            wr_v[1] = DW'($urandom_range(0, 255));
            run_dump(1, 2, 1'b0, 1'b0, -1);
        end

        // one-hot registers: checksum beat is 8'hFF when the checksum option is built in
        load_rf(1);
        run_dump(0, 0, 1'b0, 1'b0, -1);
        run_dump(1, 0, 1'b0, 1'b0, -1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
